// File: rtl/alu_op_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared types for the ALU operation dispatcher and its
//               arithmetic unit handshake (op codes, error codes, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned NUM_UNITS = 4;

    // Op code doubles as the unit index on start/working/ack/unit_result
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_DIV0    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACK       = 3'd4,
        ST_RESP      = 3'd5
    } disp_state_e;

    // One-hot unit select derived from an op code
    function automatic logic [NUM_UNITS-1:0] unit_onehot(input op_e op);
        return NUM_UNITS'(1) << op;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_op_dispatcher_if
// Description : Request channel, unit start/working/ack handshake, shared
//               operand bus and response channel of the ALU dispatcher.
//               master = dispatcher side, slave = front end / units side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_dispatcher_if #(
    parameter int DATA_W = 64
);
    // request channel
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [DATA_W-1:0]   req_a;
    logic [DATA_W-1:0]   req_b;
    // unit side
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [3:0]          start;
    logic [3:0]          working;
    logic [4*DATA_W-1:0] unit_result;
    logic [3:0]          ack_to_unit;
    // response channel
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_result;
    logic [1:0]          rsp_err;
    // status
    logic                busy;

    modport master (
        input  req_valid, req_op, req_a, req_b, working, unit_result, rsp_ready,
        output req_ready, op_a, op_b, start, ack_to_unit,
        output rsp_valid, rsp_result, rsp_err, busy
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, working, unit_result, rsp_ready,
        input  req_ready, op_a, op_b, start, ack_to_unit,
        input  rsp_valid, rsp_result, rsp_err, busy
    );

endinterface : alu_op_dispatcher_if
`default_nettype wire

// File: rtl/alu_op_dispatcher_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : alu_timeout_ctr
// Description : Saturating cycle counter with synchronous clear and an
//               expired flag raised once the count reaches LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_timeout_ctr #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    logic [CNT_W-1:0] count;

    // Count up while enabled; stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= CNT_W'(LIMIT));

endmodule : alu_timeout_ctr
`default_nettype wire

// File: rtl/alu_op_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_dispatcher
// Description : Accepts one arithmetic request at a time, issues it to the
//               add/sub/mul/div unit via start/working/ack, captures the unit
//               result and returns it on a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_dispatcher
    import alu_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_op_dispatcher_if.master bus
);

    disp_state_e       state;
    disp_state_e       next_state;
    op_e               sel;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] result_reg;
    err_e              err_reg;

    logic              accept;
    logic              div_zero;
    logic              working_sel;
    logic [DATA_W-1:0] unit_res_sel;
    logic              ctr_clear;
    logic              ctr_enable;
    logic              expired;

    assign accept       = bus.req_valid && (state == ST_IDLE);
    assign div_zero     = (op_e'(bus.req_op) == OP_DIV) && (bus.req_b == '0);
    // Only the selected unit's flag and result slice are ever looked at
    assign working_sel  = bus.working[sel];
    assign unit_res_sel = bus.unit_result[int'(sel)*DATA_W +: DATA_W];

    // Counter restarts when the start pulse goes out and again when the unit
    // reports busy, so each wait phase gets its own full timeout window
    assign ctr_clear  = (state == ST_ISSUE) || ((state == ST_WAIT_BUSY) && working_sel);
    assign ctr_enable = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);

    alu_timeout_ctr #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; unit progress wins over a timeout in the same cycle
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = div_zero ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                next_state = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (working_sel) begin
                    next_state = ST_WAIT_DONE;
                end else if (expired) begin
                    next_state = ST_RESP;
                end
            end
            ST_WAIT_DONE: begin
                if (!working_sel) begin
                    next_state = ST_ACK;
                end else if (expired) begin
                    next_state = ST_RESP;
                end
            end
            ST_ACK: begin
                next_state = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Operand latch, unit select and response result/error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sel        <= OP_ADD;
            result_reg <= '0;
            err_reg    <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg      <= bus.req_a;
                        b_reg      <= bus.req_b;
                        sel        <= op_e'(bus.req_op);
                        result_reg <= '0;
                        err_reg    <= div_zero ? ERR_DIV0 : ERR_OK;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!working_sel && expired) begin
                        result_reg <= '0;
                        err_reg    <= ERR_TIMEOUT;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!working_sel) begin
                        result_reg <= unit_res_sel;
                    end else if (expired) begin
                        result_reg <= '0;
                        err_reg    <= ERR_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state so start/ack fall with an async reset
    always_comb begin
        bus.start       = '0;
        bus.ack_to_unit = '0;
        bus.req_ready   = (state == ST_IDLE);
        bus.busy        = (state != ST_IDLE);
        bus.rsp_valid   = (state == ST_RESP);
        case (state)
            ST_ISSUE: bus.start       = unit_onehot(sel);
            ST_ACK:   bus.ack_to_unit = unit_onehot(sel);
            default: begin
            end
        endcase
    end

    assign bus.op_a       = a_reg;
    assign bus.op_b       = b_reg;
    assign bus.rsp_result = result_reg;
    assign bus.rsp_err    = err_reg;

endmodule : alu_op_dispatcher
`default_nettype wire

// File: tb/tb_alu_op_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_dispatcher
// Description : Directed self-checking bench for alu_op_dispatcher with a
//               simple behavioural model of the four arithmetic units.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_dispatcher;

    localparam int DATA_W = 64;

    logic clk;
    logic rst;

    alu_op_dispatcher_if #(.DATA_W(DATA_W)) bus ();

    alu_op_dispatcher #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (15),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int failed = 0;

    // unit model controls, written by the main sequence only
    bit                model_en  [4];
    int                model_lat [4];
    logic [DATA_W-1:0] model_res [4];

    // pulse counters, written by the monitor only
    int start_cnt [4];
    int ack_cnt   [4];
    int onehot_viol;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit model: raise working half a cycle after start, hold it lat cycles
    initial begin
        int cnt [4];
        bus.working     = '0;
        bus.unit_result = '0;
        for (int u = 0; u < 4; u++) cnt[u] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.working = '0;
                for (int u = 0; u < 4; u++) cnt[u] = 0;
            end else begin
                for (int u = 0; u < 4; u++) begin
                    if (bus.start[u] && model_en[u]) begin
                        bus.working[u] = 1'b1;
                        bus.unit_result[u*DATA_W +: DATA_W] = model_res[u];
                        cnt[u] = model_lat[u];
                    end else if (cnt[u] > 0) begin
                        cnt[u] = cnt[u] - 1;
                        if (cnt[u] == 0) bus.working[u] = 1'b0;
                    end
                end
            end
        end
    end

    // Pulse monitor
    initial begin
        for (int u = 0; u < 4; u++) begin
            start_cnt[u] = 0;
            ack_cnt[u]   = 0;
        end
        onehot_viol = 0;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 4; u++) begin
                if (bus.start[u] === 1'b1)       start_cnt[u] = start_cnt[u] + 1;
                if (bus.ack_to_unit[u] === 1'b1) ack_cnt[u]   = ack_cnt[u] + 1;
            end
            if ($countones(bus.start) > 1 || $countones(bus.ack_to_unit) > 1)
                onehot_viol = onehot_viol + 1;
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests = tests + 1;
        assert (obs === exp)
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; it is taken at the following posedge
    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Count negedges until rsp_valid; -1 if it never appears
    task automatic wait_rsp(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("idle_after_rsp", 64'(bus.busy), 64'd0);
    endtask

    function automatic int sum4(input int v [4]);
        return v[0] + v[1] + v[2] + v[3];
    endfunction

    initial begin
        int n;
        int s_base [4];
        int a_base [4];

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        for (int u = 0; u < 4; u++) begin
            model_en[u]  = 1'b1;
            model_lat[u] = 3;
            model_res[u] = '0;
        end

        // Reset values
        #2;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_start",     64'(bus.start),     64'd0);
        chk("rst_ack",       64'(bus.ack_to_unit), 64'd0);
        chk("rst_op_a",      bus.op_a,           64'd0);
        chk("rst_result",    bus.rsp_result,     64'd0);
        chk("rst_err",       64'(bus.rsp_err),   64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: add 5+7, unit busy 3 cycles
        model_lat[0] = 3;
        model_res[0] = 64'd12;
        s_base = start_cnt;
        a_base = ack_cnt;
        send(2'd0, 64'd5, 64'd7);
        chk("add_op_a",  bus.op_a, 64'd5);
        chk("add_op_b",  bus.op_b, 64'd7);
        chk("add_start", 64'(bus.start), 64'h1);
        wait_rsp(n);
        chk("add_latency", 64'(n), 64'd6);
        chk("add_result",  bus.rsp_result, 64'd12);
        chk("add_err",     64'(bus.rsp_err), 64'd0);
        #2;
        chk("add_start_pulses", 64'(start_cnt[0] - s_base[0]), 64'd1);
        chk("add_ack_pulses",   64'(ack_cnt[0] - a_base[0]),   64'd1);
        finish_rsp();

        // 2: div by zero, no start, response next cycle
        s_base = start_cnt;
        send(2'd3, 64'd100, 64'd0);
        chk("div0_no_start", 64'(bus.start), 64'd0);
        wait_rsp(n);
        chk("div0_latency", 64'(n), 64'd1);
        chk("div0_result",  bus.rsp_result, 64'd0);
        chk("div0_err",     64'(bus.rsp_err), 64'd1);
        #2;
        chk("div0_start_pulses", 64'(sum4(start_cnt) - sum4(s_base)), 64'd0);
        finish_rsp();

        // 3: mul 2^32 * 2^32, truncated result 0
        model_lat[2] = 2;
        model_res[2] = 64'd0;
        a_base = ack_cnt;
        send(2'd2, 64'h1_0000_0000, 64'h1_0000_0000);
        chk("mul_op_a", bus.op_a, 64'h1_0000_0000);
        wait_rsp(n);
        chk("mul_latency", 64'(n), 64'd5);
        chk("mul_result",  bus.rsp_result, 64'd0);
        chk("mul_err",     64'(bus.rsp_err), 64'd0);
        #2;
        chk("mul_ack2_pulses", 64'(ack_cnt[2] - a_base[2]), 64'd1);
        chk("mul_ack_total",   64'(sum4(ack_cnt) - sum4(a_base)), 64'd1);
        finish_rsp();

        // 4: sub with unit never busy -> timeout after 16 WAIT_BUSY cycles
        model_en[1] = 1'b0;
        s_base = start_cnt;
        a_base = ack_cnt;
        send(2'd1, 64'd9, 64'd4);
        wait_rsp(n);
        chk("tmo_latency", 64'(n), 64'd18);
        chk("tmo_err",     64'(bus.rsp_err), 64'd2);
        chk("tmo_result",  bus.rsp_result, 64'd0);
        #2;
        chk("tmo_start_pulses", 64'(start_cnt[1] - s_base[1]), 64'd1);
        chk("tmo_no_ack",       64'(sum4(ack_cnt) - sum4(a_base)), 64'd0);
        finish_rsp();
        model_en[1] = 1'b1;

        // 5: response back-pressure, new request waits for the handshake
        model_lat[0] = 2;
        model_res[0] = 64'd3;
        model_lat[1] = 2;
        model_res[1] = 64'd12;
        send(2'd0, 64'd1, 64'd2);
        wait_rsp(n);
        chk("bp_latency", 64'(n), 64'd5);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd1;
        bus.req_a     = 64'd20;
        bus.req_b     = 64'd8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_result",    bus.rsp_result,     64'd3);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("bp_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("bp_accepted", 64'(bus.busy), 64'd1);
        chk("bp_new_op_a", bus.op_a, 64'd20);
        wait_rsp(n);
        chk("bp_sub_result", bus.rsp_result, 64'd12);
        chk("bp_sub_err",    64'(bus.rsp_err), 64'd0);
        finish_rsp();

        // 6: reset during WAIT_DONE of a div, then a clean div
        model_lat[3] = 10;
        model_res[3] = 64'd10;
        send(2'd3, 64'd50, 64'd5);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy",      64'(bus.busy),        64'd0);
        chk("arst_req_ready", 64'(bus.req_ready),   64'd1);
        chk("arst_start",     64'(bus.start),       64'd0);
        chk("arst_ack",       64'(bus.ack_to_unit), 64'd0);
        chk("arst_op_a",      bus.op_a,             64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        model_lat[3] = 3;
        model_res[3] = 64'd14;
        send(2'd3, 64'd100, 64'd7);
        wait_rsp(n);
        chk("post_rst_latency", 64'(n), 64'd6);
        chk("post_rst_result",  bus.rsp_result, 64'd14);
        chk("post_rst_err",     64'(bus.rsp_err), 64'd0);
        finish_rsp();

        #2;
        chk("onehot_start_ack", 64'(onehot_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_alu_op_dispatcher
`default_nettype wire
